// File: rtl/opl3_pkg.sv
// Shared constants for the OPL3 host port: timer register indices, CTRL bit
// positions and the emulated status byte layout.
package opl3_pkg;

  localparam logic [7:0] OPL_T1PRE = 8'h02;
  localparam logic [7:0] OPL_T2PRE = 8'h03;
  localparam logic [7:0] OPL_TCTRL = 8'h04;

  localparam int CTRL_RST   = 7;
  localparam int CTRL_MASK1 = 6;
  localparam int CTRL_MASK2 = 5;
  localparam int CTRL_ST2   = 1;
  localparam int CTRL_ST1   = 0;

  localparam int STAT_IRQ = 7;
  localparam int STAT_FT1 = 6;
  localparam int STAT_FT2 = 5;

  typedef enum logic [1:0] {
    PORT_IDX0  = 2'd0,
    PORT_DATA0 = 2'd1,
    PORT_IDX1  = 2'd2,
    PORT_DATA1 = 2'd3
  } opl_port_e;

  typedef struct packed {
    logic mask1;
    logic mask2;
    logic st2;
    logic st1;
  } tctrl_t;

  function automatic logic [7:0] make_status(input logic flag1, input logic flag2);
    logic [7:0] s;
    s           = '0;
    s[STAT_IRQ] = flag1 | flag2;
    s[STAT_FT1] = flag1;
    s[STAT_FT2] = flag2;
    return s;
  endfunction

endpackage

// File: rtl/opl_timer.sv
// One OPL interval timer: 8-bit up-counter reloaded from its preset on
// overflow, raising a sticky flag unless masked.
module opl_timer
  import opl3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] preset,
  input  logic       start,
  input  logic       mask,
  input  logic       clear,
  output logic       flag
);

  logic [7:0] cnt;
  logic       start_q;
  logic       overflow;

  // The load cycle on a 0->1 start takes precedence over any tick in it.
  assign overflow = start && start_q && tick && (cnt == 8'hFF);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      start_q <= 1'b0;
      flag    <= 1'b0;
    end else begin
      start_q <= start;
      if (start && !start_q) begin
        cnt <= preset;
      end else if (overflow) begin
        cnt <= preset;
      end else if (start && tick) begin
        cnt <= cnt + 8'd1;
      end

      if (clear) begin
        flag <= 1'b0;
      end else if (overflow && !mask) begin
        flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/opl3_isa_port.sv
// ISA front end of the OPL3 synth: forwards decoded IOW cycles to the opl3sw
// FIFO and answers status polls from locally emulated OPL timers.
module opl3_isa_port
  import opl3_pkg::*;
#(
  parameter int         CLK_HZ = 50000000,
  parameter logic [9:0] BASE   = 10'h388
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] isa_addr,
  input  logic       isa_aen,
  input  logic       isa_iow_n,
  input  logic       isa_ior_n,
  input  logic [7:0] isa_din,
  output logic [7:0] isa_dout,
  output logic       isa_dout_oe,
  output logic [1:0] opl_addr,
  output logic [7:0] opl_din,
  output logic       opl_wr,
  output logic       irq
);

  localparam int TICK_DIV = CLK_HZ / 12500;
  localparam int DIV_W    = $clog2(TICK_DIV);

  logic             hit;
  logic [1:0]       iow_sync;
  logic             iow_s;
  logic             iow_prev;
  logic             cap_hit;
  logic [1:0]       cap_addr;
  logic [7:0]       cap_data;
  logic             wr_commit;
  logic [7:0]       index;
  logic             bank;
  logic [7:0]       t1pre;
  logic [7:0]       t2pre;
  tctrl_t           ctrl;
  logic             timer_wr;
  logic             tclear;
  logic [DIV_W-1:0] div;
  logic [1:0]       sub;
  logic             tick80;
  logic             tick320;
  logic             flag1;
  logic             flag2;
  logic [7:0]       status;

  assign hit   = !isa_aen && (isa_addr[9:2] == BASE[9:2]);
  assign iow_s = iow_sync[1];

  // Commit on the synchronised IOW rising edge; opl_wr follows one clk later.
  assign wr_commit = iow_s && !iow_prev && cap_hit;
  assign timer_wr  = wr_commit && (opl_port_e'(cap_addr) == PORT_DATA0) && !bank;
  assign tclear    = timer_wr && (index == OPL_TCTRL) && cap_data[CTRL_RST];

  assign opl_addr = cap_addr;
  assign opl_din  = cap_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      iow_sync <= 2'b11;
      iow_prev <= 1'b1;
      cap_hit  <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      opl_wr   <= 1'b0;
      index    <= '0;
      bank     <= 1'b0;
      t1pre    <= '0;
      t2pre    <= '0;
      ctrl     <= '0;
    end else begin
      iow_sync <= {iow_sync[0], isa_iow_n};
      iow_prev <= iow_s;
      opl_wr   <= wr_commit;

      if (!iow_s) begin
        cap_hit <= hit;
        if (hit) begin
          cap_addr <= isa_addr[1:0];
          cap_data <= isa_din;
        end
      end

      if (wr_commit) begin
        case (opl_port_e'(cap_addr))
          PORT_IDX0: begin
            index <= cap_data;
            bank  <= 1'b0;
          end
          PORT_IDX1: begin
            index <= cap_data;
            bank  <= 1'b1;
          end
          default: ;
        endcase
      end

      if (timer_wr) begin
        if (index == OPL_T1PRE) t1pre <= cap_data;
        if (index == OPL_T2PRE) t2pre <= cap_data;
        if (index == OPL_TCTRL && !cap_data[CTRL_RST]) begin
          ctrl <= '{mask1: cap_data[CTRL_MASK1], mask2: cap_data[CTRL_MASK2],
                    st2:   cap_data[CTRL_ST2],   st1:   cap_data[CTRL_ST1]};
        end
      end
    end
  end

  assign tick80  = (div == DIV_W'(TICK_DIV - 1));
  assign tick320 = tick80 && (sub == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      sub <= '0;
    end else if (tick80) begin
      div <= '0;
      sub <= sub + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  opl_timer u_timer1 (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick80),
    .preset (t1pre),
    .start  (ctrl.st1),
    .mask   (ctrl.mask1),
    .clear  (tclear),
    .flag   (flag1)
  );

  opl_timer u_timer2 (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick320),
    .preset (t2pre),
    .start  (ctrl.st2),
    .mask   (ctrl.mask2),
    .clear  (tclear),
    .flag   (flag2)
  );

  assign status = make_status(flag1, flag2);
  assign irq    = flag1 | flag2;

  // Raw, unsynchronised read path so SD turns on as soon as IOR# falls.
  assign isa_dout_oe = !isa_ior_n && hit;
  assign isa_dout    = isa_addr[0] ? 8'hFF : status;

endmodule

// File: tb/tb_opl3_isa_port.sv
// Randomised self-checking bench for opl3_isa_port against a tick-counting
// reference model of the OPL timers and a scoreboard of forwarded writes.
module tb_opl3_isa_port;

  localparam int         CLK_HZ = 50000000;
  localparam logic [9:0] BASE   = 10'h388;
  localparam longint     D80    = CLK_HZ / 12500;
  localparam longint     D320   = 4 * D80;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] isa_addr;
  logic       isa_aen;
  logic       isa_iow_n;
  logic       isa_ior_n;
  logic [7:0] isa_din;
  logic [7:0] isa_dout;
  logic       isa_dout_oe;
  logic [1:0] opl_addr;
  logic [7:0] opl_din;
  logic       opl_wr;
  logic       irq;

  opl3_isa_port #(.CLK_HZ(CLK_HZ), .BASE(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .isa_addr    (isa_addr),
    .isa_aen     (isa_aen),
    .isa_iow_n   (isa_iow_n),
    .isa_ior_n   (isa_ior_n),
    .isa_din     (isa_din),
    .isa_dout    (isa_dout),
    .isa_dout_oe (isa_dout_oe),
    .opl_addr    (opl_addr),
    .opl_din     (opl_din),
    .opl_wr      (opl_wr),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc;

  // Cycles since reset release; tick80 number k lands on cycle k*D80.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  logic [9:0] obs[$];
  always @(negedge clk) if (opl_wr) obs.push_back({opl_addr, opl_din});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: register file plus start/stop/clear times of each timer.
  logic [7:0] m_index, m_t1pre, m_t2pre, m_p1, m_p2;
  logic       m_bank, m_mask1, m_mask2, m_st1, m_st2, m_ever1, m_ever2;
  longint     m_s1, m_s2, m_e1, m_e2, m_clr;

  task automatic model_reset();
    m_index = 0; m_bank = 0; m_t1pre = 0; m_t2pre = 0; m_p1 = 0; m_p2 = 0;
    m_mask1 = 0; m_mask2 = 0; m_st1 = 0; m_st2 = 0; m_ever1 = 0; m_ever2 = 0;
    m_s1 = 0; m_s2 = 0; m_e1 = 0; m_e2 = 0; m_clr = -1;
  endtask

  task automatic model_write(input logic [1:0] off, input logic [7:0] d, input longint now);
    case (off)
      2'd0: begin m_index = d; m_bank = 0; end
      2'd2: begin m_index = d; m_bank = 1; end
      2'd1: if (!m_bank) begin
        if (m_index == 8'h02) m_t1pre = d;
        if (m_index == 8'h03) m_t2pre = d;
        if (m_index == 8'h04) begin
          if (d[7]) m_clr = now;
          else begin
            m_mask1 = d[6]; m_mask2 = d[5];
            if (d[0] && !m_st1) begin m_s1 = now; m_p1 = m_t1pre; m_ever1 = 1; end
            if (!d[0] && m_st1) m_e1 = now;
            if (d[1] && !m_st2) begin m_s2 = now; m_p2 = m_t2pre; m_ever2 = 1; end
            if (!d[1] && m_st2) m_e2 = now;
            m_st1 = d[0]; m_st2 = d[1];
          end
        end
      end
      default: ;
    endcase
  endtask

  // A timer started with preset p overflows every (256-p) ticks after start.
  function automatic logic flag_of(input logic ever, input logic run, input longint s,
                                   input longint e, input logic [7:0] p, input longint d,
                                   input logic mask, input longint now);
    longint upto, ks, kn, per, last;
    if (!ever || mask) return 1'b0;
    upto = run ? now : e;
    per  = 256 - longint'(p);
    ks   = s / d;
    kn   = upto / d;
    if (kn - ks < per) return 1'b0;
    last = (ks + per * ((kn - ks) / per)) * d;
    return last > m_clr;
  endfunction

  function automatic logic [7:0] exp_status();
    logic f1, f2;
    f1 = flag_of(m_ever1, m_st1, m_s1, m_e1, m_p1, D80,  m_mask1, cyc);
    f2 = flag_of(m_ever2, m_st2, m_s2, m_e2, m_p2, D320, m_mask2, cyc);
    return {f1 | f2, f1, f2, 5'b00000};
  endfunction

  // Keep bus activity well clear of tick boundaries so model timing is exact.
  task automatic wait_safe();
    while ((cyc % D80) < 50 || (cyc % D80) > D80 - 100) @(negedge clk);
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic isa_write(input string tag, input logic [9:0] a, input logic [7:0] d,
                           input logic aen);
    logic        take;
    logic [31:0] got, exp;
    int          n;
    wait_safe();
    @(negedge clk);
    isa_addr = a; isa_din = d; isa_aen = aen; isa_iow_n = 1'b0;
    repeat (4) @(negedge clk);
    isa_iow_n = 1'b1;
    take = !aen && (a[9:2] == BASE[9:2]);
    if (take) model_write(a[1:0], d, cyc);
    repeat (6) @(negedge clk);
    isa_aen = 1'b0; isa_addr = 10'h000;
    n   = obs.size();
    got = {8'(n), 14'd0, (n > 0) ? obs[0] : 10'd0};
    exp = take ? {8'd1, 14'd0, a[1:0], d} : 32'd0;
    check(tag, got, exp);
    obs.delete();
  endtask

  task automatic isa_read(input string tag, input logic [9:0] a, input logic aen);
    logic hit_m;
    @(negedge clk);
    isa_addr = a; isa_aen = aen; isa_ior_n = 1'b0;
    #1;
    hit_m = !aen && (a[9:2] == BASE[9:2]);
    check({tag, "_oe"}, 32'(isa_dout_oe), 32'(hit_m));
    if (hit_m) check({tag, "_dout"}, 32'(isa_dout), a[0] ? 32'hFF : 32'(exp_status()));
    isa_ior_n = 1'b1; isa_addr = 10'h000; isa_aen = 1'b0;
  endtask

  task automatic check_status(input string tag);
    isa_read(tag, BASE, 1'b0);
    check({tag, "_irq"}, 32'(irq), 32'(exp_status() != 8'h00));
  endtask

  initial begin
    logic [9:0] a;
    logic [7:0] d;
    logic [1:0] off;
    int         r;

    isa_addr = 0; isa_aen = 0; isa_iow_n = 1; isa_ior_n = 1; isa_din = 0;
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_opl_wr", 32'(opl_wr), 0);
    check("rst_opl_addr", 32'(opl_addr), 0);
    check("rst_opl_din", 32'(opl_din), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_oe", 32'(isa_dout_oe), 0);
    reset = 1'b0;

    // Masks set, timers idle.
    isa_write("wr_idx04", BASE + 10'd0, 8'h04, 1'b0);
    isa_write("wr_ctrl60", BASE + 10'd1, 8'h60, 1'b0);
    check_status("st_masked");

    // Bank 1 traffic must never touch the local timers.
    isa_write("wr_b1_idx", BASE + 10'd2, 8'h04, 1'b0);
    isa_write("wr_b1_dat", BASE + 10'd3, 8'h21, 1'b0);
    check_status("st_bank1_early");
    wait_until(D80 + D80 / 2);
    check_status("st_bank1_late");

    // Decode edges.
    isa_write("wr_miss_38c", 10'h38C, 8'h11, 1'b0);
    isa_write("wr_miss_aen", BASE + 10'd1, 8'h22, 1'b1);
    isa_read("rd_389", BASE + 10'd1, 1'b0);
    isa_read("rd_390", 10'h390, 1'b0);

    // AdLib detection sequence.
    isa_write("det_i1", BASE, 8'h04, 1'b0);
    isa_write("det_d1", BASE + 10'd1, 8'h60, 1'b0);
    isa_write("det_d2", BASE + 10'd1, 8'h80, 1'b0);
    isa_write("det_i3", BASE, 8'h02, 1'b0);
    isa_write("det_d3", BASE + 10'd1, 8'hFF, 1'b0);
    isa_write("det_i4", BASE, 8'h04, 1'b0);
    isa_write("det_d4", BASE + 10'd1, 8'h21, 1'b0);
    check_status("det_before");
    wait_until(cyc + 5000);
    wait_safe();
    check_status("det_after");
    isa_write("det_clr", BASE + 10'd1, 8'h80, 1'b0);
    check_status("det_cleared");
    isa_write("det_stop", BASE + 10'd1, 8'h00, 1'b0);

    // Timer 2 with preset 0xFE overflows on its second tick320.
    isa_write("t2_i", BASE, 8'h03, 1'b0);
    isa_write("t2_pre", BASE + 10'd1, 8'hFE, 1'b0);
    isa_write("t2_ic", BASE, 8'h04, 1'b0);
    isa_write("t2_go", BASE + 10'd1, 8'h02, 1'b0);
    wait_until(((cyc / D320) + 1) * D320 + D80 * 2);
    check_status("t2_one_tick");
    wait_until(((cyc / D320) + 1) * D320 + D80 * 2);
    check_status("t2_two_ticks");
    isa_write("t2_clr", BASE + 10'd1, 8'h80, 1'b0);
    check_status("t2_cleared");
    isa_write("t2_stop", BASE + 10'd1, 8'h00, 1'b0);

    // Randomised traffic; index never lands on a timer register here.
    isa_write("rnd_idx", BASE, 8'h01, 1'b0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      if (r <= 1) begin
        off = 2'($urandom_range(0, 3));
        d   = 8'($urandom);
        if ((off == 2'd0 || off == 2'd2) && d >= 8'h02 && d <= 8'h04) d = d | 8'h10;
        isa_write("rnd_wr", {BASE[9:2], off}, d, 1'b0);
      end else if (r == 2) begin
        a = 10'($urandom);
        if (a[9:2] == BASE[9:2]) a = a ^ 10'h100;
        if ($urandom_range(0, 1) == 1) a = {BASE[9:2], a[1:0]};
        isa_write("rnd_miss", a, 8'($urandom), a[9:2] == BASE[9:2]);
      end else begin
        a = 10'($urandom);
        if ($urandom_range(0, 1) == 1) a = {BASE[9:2], a[1:0]};
        isa_read("rnd_rd", a, $urandom_range(0, 3) == 0);
      end
    end

    // Reset in the middle of an IOW cycle.
    @(negedge clk);
    isa_addr = BASE + 10'd1; isa_din = 8'h55; isa_iow_n = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_opl_wr", 32'(opl_wr), 0);
    check("mid_rst_opl_addr", 32'(opl_addr), 0);
    check("mid_rst_opl_din", 32'(opl_din), 0);
    check("mid_rst_irq", 32'(irq), 0);
    isa_iow_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    isa_addr = 10'h000;
    check("mid_rst_no_wr", 32'(obs.size()), 0);
    obs.delete();
    isa_write("post_rst_wr", BASE + 10'd2, 8'h5A, 1'b0);
    check_status("post_rst_st");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
